// File: rtl/cascade_digit_counter_pkg.sv
// Shared definitions for the cascaded digit counter: digit width, legal radices
// and a helper giving the packed width of an N-digit vector.
package cascade_digit_counter_pkg;

    localparam int DIGIT_W   = 4;
    localparam int RADIX_HEX = 16;
    localparam int RADIX_DEC = 10;

    typedef logic [DIGIT_W-1:0] digit_t;

    function automatic int digits_width(input int num_digits);
        return num_digits * DIGIT_W;
    endfunction

endpackage

// File: rtl/cascade_digit_counter_digit_cell.sv
// One counter digit: registered value with load clamping, wrap at the radix
// boundary and a combinational carry/borrow towards the next digit.
module cascade_digit_counter_digit_cell
    import cascade_digit_counter_pkg::*;
#(
    parameter int RADIX = RADIX_HEX
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   step_en,
    input  logic   up,
    input  logic   carry_in,
    input  logic   load,
    input  digit_t load_nibble,
    output digit_t digit,
    output logic   carry_out
);

    localparam digit_t DIGIT_MAX = digit_t'(RADIX - 1);

    digit_t digit_q;
    digit_t digit_d;
    logic   at_edge;

    // at_edge: this digit wraps on the current step, so the next digit must move too
    always_comb begin
        at_edge   = up ? (digit_q == DIGIT_MAX) : (digit_q == '0);
        carry_out = carry_in & at_edge;
        digit_d   = digit_q;
        if (load) begin
            digit_d = (load_nibble > DIGIT_MAX) ? DIGIT_MAX : load_nibble;
        end else if (step_en && carry_in) begin
            if (at_edge) begin
                digit_d = up ? digit_t'(0) : DIGIT_MAX;
            end else begin
                digit_d = up ? digit_q + digit_t'(1) : digit_q - digit_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/cascade_digit_counter.sv
// Multi-digit up/down counter driven by a rate-divider tick, with parallel load,
// hex or decimal digits, a terminal-count pulse and an update pulse.
module cascade_digit_counter
    import cascade_digit_counter_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int RADIX      = RADIX_HEX,
    localparam int W          = digits_width(NUM_DIGITS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         run,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] digits,
    output logic         tc,
    output logic         changed
);

    logic              step_en;
    logic [NUM_DIGITS:0] carry;
    logic              tc_q, tc_d;
    logic              changed_q, changed_d;

    // load outranks a coincident tick, so the step is suppressed here
    assign step_en  = run & tick & ~load;
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            cascade_digit_counter_digit_cell #(
                .RADIX(RADIX)
            ) u_cell (
                .clk        (clk),
                .reset      (reset),
                .step_en    (step_en),
                .up         (up),
                .carry_in   (carry[gi]),
                .load       (load),
                .load_nibble(load_val[gi*DIGIT_W +: DIGIT_W]),
                .digit      (digits[gi*DIGIT_W +: DIGIT_W]),
                .carry_out  (carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        tc_d      = step_en & carry[NUM_DIGITS];
        changed_d = load | step_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tc_q      <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            tc_q      <= tc_d;
            changed_q <= changed_d;
        end
    end

    assign tc      = tc_q;
    assign changed = changed_q;

endmodule
